// File: rtl/ahb_page_table_if.sv
// AHB-Lite subset used by the page table: address/data phase signals only,
// no HREADY input since the slave never inserts wait states.
interface ahb_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;

    modport ahb_s (
        input  HSEL, HADDR, HWRITE, HTRANS, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );

    modport ahb_m (
        output HSEL, HADDR, HWRITE, HTRANS, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_page_table.sv
// Single-level page table: PTEs programmed over AHB, one-cycle translation
// behind a single-entry valid/ready output stage, with saturating fault count.
module ahb_page_table #(
    parameter int NUM_VPAGES    = 32,
    parameter int PPN_W         = 3,
    parameter int PAGE_OFFSET_W = 12,
    parameter int ADDR_W        = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    ahb_if.ahb_s              ahb_s,
    input  logic              tr_req,
    input  logic [ADDR_W-1:0] tr_vaddr,
    input  logic              tr_write,
    output logic              tr_ready,
    output logic              tr_valid,
    output logic [ADDR_W-1:0] tr_paddr,
    output logic              tr_fault,
    input  logic              tr_resp_ready,
    output logic [15:0]       fault_count
);
    localparam int VPN_W = $clog2(NUM_VPAGES);
    localparam int IDX_W = VPN_W + 1;
    localparam logic [IDX_W-1:0] CTRL_IDX   = IDX_W'(NUM_VPAGES);
    localparam logic [IDX_W-1:0] FAULTS_IDX = IDX_W'(NUM_VPAGES + 1);

    logic [NUM_VPAGES-1:0]            pte_v;
    logic [NUM_VPAGES-1:0]            pte_w;
    logic [NUM_VPAGES-1:0][PPN_W-1:0] pte_ppn;

    logic             ph_vld;
    logic             ph_wr;
    logic [IDX_W-1:0] ph_idx;
    logic [VPN_W-1:0] pte_idx;
    logic             wr_en, pte_sel, inval, fclr;
    logic [31:0]      rdata;

    // Address phase: capture the transfer so the data phase can act on it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ph_vld <= 1'b0;
            ph_wr  <= 1'b0;
            ph_idx <= '0;
        end else if (ahb_s.HSEL && ahb_s.HTRANS[1]) begin
            ph_vld <= 1'b1;
            ph_wr  <= ahb_s.HWRITE;
            ph_idx <= ahb_s.HADDR[VPN_W+2:2];
        end else begin
            ph_vld <= 1'b0;
        end
    end

    assign pte_idx = ph_idx[VPN_W-1:0];
    assign wr_en   = ph_vld & ph_wr;
    assign pte_sel = wr_en & ~ph_idx[VPN_W];
    assign inval   = wr_en & (ph_idx == CTRL_IDX) & ahb_s.HWDATA[0];
    assign fclr    = wr_en & (ph_idx == FAULTS_IDX);

    // Invalidate and a PTE write can never coincide: both decode ph_idx.
    for (genvar g = 0; g < NUM_VPAGES; g++) begin : g_pte
        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                pte_v[g]   <= 1'b0;
                pte_w[g]   <= 1'b0;
                pte_ppn[g] <= '0;
            end else if (pte_sel && (pte_idx == VPN_W'(g))) begin
                pte_v[g]   <= ahb_s.HWDATA[0];
                pte_w[g]   <= ahb_s.HWDATA[1];
                pte_ppn[g] <= ahb_s.HWDATA[PPN_W+1:2];
            end else if (inval) begin
                pte_v[g]   <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (ph_vld && !ph_wr) begin
            if (!ph_idx[VPN_W]) begin
                rdata[0]         = pte_v[pte_idx];
                rdata[1]         = pte_w[pte_idx];
                rdata[PPN_W+1:2] = pte_ppn[pte_idx];
            end else if (ph_idx == FAULTS_IDX) begin
                rdata[15:0] = fault_count;
            end
        end
    end

    assign ahb_s.HRDATA    = rdata;
    assign ahb_s.HREADYOUT = 1'b1;
    assign ahb_s.HRESP     = 2'b00;

    logic [VPN_W-1:0]  vpn;
    logic              oor, flt;
    logic [ADDR_W-1:0] ok_paddr;

    assign vpn = tr_vaddr[PAGE_OFFSET_W +: VPN_W];
    assign oor = |(tr_vaddr >> (PAGE_OFFSET_W + VPN_W));
    assign flt = oor | ~pte_v[vpn] | (tr_write & ~pte_w[vpn]);

    always_comb begin
        ok_paddr = '0;
        ok_paddr[PAGE_OFFSET_W-1:0]      = tr_vaddr[PAGE_OFFSET_W-1:0];
        ok_paddr[PAGE_OFFSET_W +: PPN_W] = pte_ppn[vpn];
    end

    assign tr_ready = ~tr_valid | tr_resp_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tr_valid <= 1'b0;
            tr_fault <= 1'b0;
            tr_paddr <= '0;
        end else if (tr_req && tr_ready) begin
            tr_valid <= 1'b1;
            tr_fault <= flt;
            tr_paddr <= flt ? '0 : ok_paddr;
        end else if (tr_resp_ready) begin
            tr_valid <= 1'b0;
        end
    end

    // Software clear beats a fault retiring on the same edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            fault_count <= '0;
        else if (fclr)
            fault_count <= '0;
        else if (tr_valid && tr_resp_ready && tr_fault && !(&fault_count))
            fault_count <= fault_count + 16'd1;
    end

    logic unused_ok;
    assign unused_ok = ^{ahb_s.HADDR[31:VPN_W+3], ahb_s.HADDR[1:0],
                         ahb_s.HTRANS[0], ahb_s.HWDATA[31:PPN_W+2]};
endmodule

// File: tb/tb_ahb_page_table.sv
// Directed bench for ahb_page_table: AHB programming, translation scoreboard,
// backpressure, invalidate/clear races, counter saturation and async reset.
module tb_ahb_page_table;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        tr_req, tr_write, tr_ready, tr_valid, tr_fault, tr_resp_ready;
    logic [31:0] tr_vaddr, tr_paddr;
    logic [15:0] fault_count;

    always #5 CLK = ~CLK;

    ahb_if bus();

    ahb_page_table dut (
        .CLK(CLK), .nRST(nRST), .ahb_s(bus),
        .tr_req(tr_req), .tr_vaddr(tr_vaddr), .tr_write(tr_write),
        .tr_ready(tr_ready), .tr_valid(tr_valid), .tr_paddr(tr_paddr),
        .tr_fault(tr_fault), .tr_resp_ready(tr_resp_ready),
        .fault_count(fault_count)
    );

    typedef struct packed {
        logic [31:0] paddr;
        logic        fault;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_pte[32];
    logic [15:0] exp_fc = '0;
    int          vectors = 0, miscompares = 0, resp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] va, input logic wr);
        exp_t        e;
        logic [31:0] pte;
        pte     = m_pte[va[16:12]];
        e.fault = (va[31:17] != 0) || !pte[0] || (wr && !pte[1]);
        e.paddr = e.fault ? 32'h0 : {17'h0, pte[4:2], va[11:0]};
        return e;
    endfunction

    // Scoreboard: push at acceptance, compare the head every valid cycle.
    always @(negedge CLK) begin
        if (!nRST) begin
            q.delete();
        end else begin
            if (tr_valid) begin
                if (q.size() == 0) begin
                    chk("resp_unexpected", {31'h0, tr_valid}, 32'h0);
                end else begin
                    chk("resp_paddr", tr_paddr, q[0].paddr);
                    chk("resp_fault", {31'h0, tr_fault}, {31'h0, q[0].fault});
                    if (tr_resp_ready) begin
                        if (q[0].fault && exp_fc != 16'hFFFF) exp_fc++;
                        void'(q.pop_front());
                        resp_cnt++;
                    end
                end
            end
            if (tr_req && tr_ready) q.push_back(model(tr_vaddr, tr_write));
        end
    end

    task automatic ahb_write(input int idx, input logic [31:0] data);
        @(posedge CLK) #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = idx << 2;
        @(posedge CLK) #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = data;
        @(posedge CLK);
        if (idx < 32) m_pte[idx] = data & 32'h1F;
        if (idx == 32 && data[0]) foreach (m_pte[i]) m_pte[i][0] = 1'b0;
        if (idx == 33) exp_fc = '0;
    endtask

    task automatic ahb_read(input int idx, input logic [31:0] exp, input string tag);
        @(posedge CLK) #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = idx << 2;
        @(posedge CLK) #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        @(negedge CLK);
        chk(tag, bus.HRDATA, exp);
    endtask

    task automatic send(input logic [31:0] va, input logic wr);
        @(posedge CLK) #1;
        tr_req = 1'b1; tr_vaddr = va; tr_write = wr;
        @(posedge CLK) #1;
        tr_req = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && (tr_valid || q.size() != 0); n++) begin
            @(negedge CLK) #1;
        end
        chk("drain_q", q.size(), 32'h0);
        chk("drain_valid", {31'h0, tr_valid}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, base;
        logic acc;
        bus.HSEL = 0; bus.HADDR = 0; bus.HWRITE = 0; bus.HTRANS = 0; bus.HWDATA = 0;
        tr_req = 0; tr_vaddr = 0; tr_write = 0; tr_resp_ready = 1;
        foreach (m_pte[i]) m_pte[i] = '0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_valid", {31'h0, tr_valid}, 32'h0);
        chk("rst_fault", {31'h0, tr_fault}, 32'h0);
        chk("rst_paddr", tr_paddr, 32'h0);
        chk("rst_fcount", {16'h0, fault_count}, 32'h0);
        chk("rst_hrdata", bus.HRDATA, 32'h0);
        chk("rst_hready", {31'h0, bus.HREADYOUT}, 32'h1);
        chk("rst_hresp", {30'h0, bus.HRESP}, 32'h0);
        chk("rst_tr_ready", {31'h0, tr_ready}, 32'h1);
        @(posedge CLK) #1 nRST = 1'b1;

        // Program, read back, translate with one-cycle latency
        ahb_write(5, 32'h0000_000F);
        ahb_read(5, 32'h0000_000F, "pte5_rd");
        @(posedge CLK) #1;
        tr_req = 1'b1; tr_vaddr = 32'h0000_5ABC; tr_write = 1'b0;
        @(negedge CLK) #1;
        chk("lat_before_accept", {31'h0, tr_valid}, 32'h0);
        @(posedge CLK) #1 tr_req = 1'b0;
        @(negedge CLK) #1;
        chk("lat_valid", {31'h0, tr_valid}, 32'h1);
        chk("lat_paddr", tr_paddr, 32'h0000_3ABC);
        chk("lat_fault", {31'h0, tr_fault}, 32'h0);
        drain();

        // Pipelined write then read of PTE[7]; upper write bits are dropped
        @(posedge CLK) #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 7 << 2;
        @(posedge CLK) #1;
        bus.HWDATA = 32'hFFFF_FFFB; bus.HTRANS = 2'b11; bus.HWRITE = 1'b0;
        @(posedge CLK);
        m_pte[7] = 32'h1B;
        #1 bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        @(negedge CLK);
        chk("raw_pte7", bus.HRDATA, 32'h0000_001B);

        // Write permission
        ahb_write(2, 32'h0000_0009);
        send(32'h0000_2010, 1'b1);
        send(32'h0000_2010, 1'b0);
        drain();
        chk("fc_after_store", {16'h0, fault_count}, 32'h1);

        // Out-of-range and invalid page
        send(32'h0002_0000, 1'b0);
        send(32'h0000_3000, 1'b0);
        drain();
        chk("fc_three", {16'h0, fault_count}, {16'h0, exp_fc});
        ahb_read(33, 32'h0000_0003, "faults_rd");

        // Backpressure for 3 cycles, then streaming
        base = resp_cnt; n = 0;
        @(posedge CLK) #1;
        tr_resp_ready = 1'b0; tr_req = 1'b1; tr_vaddr = 32'h0000_5000; tr_write = 1'b0;
        for (int cyc = 0; cyc < 30 && tr_req; cyc++) begin
            @(negedge CLK);
            acc = tr_req && tr_ready;
            if (cyc >= 1 && cyc <= 3) chk("bp_ready_low", {31'h0, tr_ready}, 32'h0);
            if (cyc >= 4) chk("stream_accept", {31'h0, acc}, 32'h1);
            @(posedge CLK) #1;
            if (acc) begin
                n++;
                if (n == 6) tr_req = 1'b0;
                else begin
                    tr_vaddr = (n == 3) ? 32'h0000_2010 : 32'h0000_5000 + n * 16;
                    tr_write = (n == 3);
                end
            end
            tr_resp_ready = (cyc >= 3);
        end
        tr_req = 1'b0; tr_resp_ready = 1'b1;
        drain();
        chk("bp_accepts", n, 32'd6);
        chk("bp_responses", resp_cnt - base, 32'd6);

        // Invalidate committing on the same edge a VPN 5 request is accepted
        @(posedge CLK) #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 32 << 2;
        @(posedge CLK) #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = 32'h1;
        tr_req = 1'b1; tr_vaddr = 32'h0000_5123; tr_write = 1'b0;
        @(posedge CLK);
        foreach (m_pte[i]) m_pte[i][0] = 1'b0;
        #1 tr_req = 1'b0;
        drain();
        send(32'h0000_5123, 1'b0);
        drain();
        ahb_read(5, 32'h0000_000E, "pte5_inval");
        ahb_read(7, 32'h0000_001A, "pte7_inval");

        // Fault retiring on the same edge as a FAULTS write
        @(posedge CLK) #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 33 << 2;
        tr_req = 1'b1; tr_vaddr = 32'h0000_5000; tr_write = 1'b0;
        @(posedge CLK) #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = 32'h0; tr_req = 1'b0;
        @(posedge CLK);
        exp_fc = '0;
        drain();
        chk("fc_clear_wins", {16'h0, fault_count}, 32'h0);

        // Saturation
        @(posedge CLK) #1;
        tr_req = 1'b1; tr_vaddr = 32'h0002_0000; tr_write = 1'b0;
        repeat (65540) @(posedge CLK);
        #1 tr_req = 1'b0;
        drain();
        chk("fc_saturated", {16'h0, fault_count}, 32'h0000_FFFF);
        chk("fc_model", {16'h0, fault_count}, {16'h0, exp_fc});
        ahb_read(33, 32'h0000_FFFF, "faults_sat_rd");

        // Asynchronous reset with a response in flight
        @(posedge CLK) #1;
        tr_resp_ready = 1'b0; tr_req = 1'b1; tr_vaddr = 32'h0000_7000;
        @(posedge CLK) #1 tr_req = 1'b0;
        #2 nRST = 1'b0;
        #1;
        chk("arst_valid", {31'h0, tr_valid}, 32'h0);
        chk("arst_fcount", {16'h0, fault_count}, 32'h0);
        @(posedge CLK) #1;
        nRST = 1'b1; tr_resp_ready = 1'b1; exp_fc = '0;
        foreach (m_pte[i]) m_pte[i] = '0;
        ahb_read(7, 32'h0, "arst_pte7");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
